// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle processor control path.
// Holds the FSM state encodings, the supported opcodes, the ALUOp,
// ALUSrcB and PCSource select codes, and the packed control word.
// The ALU control and the datapath muxes import the same codes.
package multicycle_ctrl_pkg;

  localparam int OPW = 6;  // opcode field width, instr[31:26]
  localparam int STW = 4;  // state register width

  typedef enum logic [STW-1:0] {
    S_IF     = 4'd0,
    S_ID     = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_IMMEX  = 4'd9,
    S_IMMWB  = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPW-1:0] OP_LW    = 6'b100011;
  localparam logic [OPW-1:0] OP_SW    = 6'b101011;
  localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPW-1:0] OP_J     = 6'b000010;
  localparam logic [OPW-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPW-1:0] OP_ORI   = 6'b001101;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OR    = 2'b11;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_word_t;

  // True for every opcode the FSM knows how to sequence.
  function automatic logic op_supported(input logic [OPW-1:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ORI: return 1'b1;
      default:                                               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control interface between the main FSM and the datapath.
// master (controller): takes opcode/mem_ready, drives all selects/enables,
//   the bad_op pulse and the debug state.
// slave (datapath/memory side): the mirror image.
interface multicycle_ctrl_if;
  import multicycle_ctrl_pkg::*;

  logic [OPW-1:0] opcode;
  logic           mem_ready;
  logic           pc_write;
  logic           pc_write_cond;
  logic           iord;
  logic           mem_read;
  logic           mem_write;
  logic           ir_write;
  logic           reg_dst;
  logic           mem_to_reg;
  logic           reg_write;
  logic           alu_src_a;
  logic [1:0]     alu_src_b;
  logic [1:0]     alu_op;
  logic [1:0]     pc_source;
  logic           bad_op;
  logic [STW-1:0] state;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, bad_op, state
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, bad_op, state
  );

endinterface

// File: rtl/multicycle_ctrl_out_decode.sv
// Moore output decode of the control FSM.
// Purely combinational: state (+mem_ready for the IF stall, +opcode for the
// ori/addi ALU op) -> control word.
//   state     in  current FSM state
//   mem_ready in  memory handshake, gates PC/IR load during IF
//   opcode    in  held IR opcode, distinguishes ori from addi in IMMEX
//   ctrl      out full control word
module multicycle_ctrl_out_decode
  import multicycle_ctrl_pkg::*;
(
  input  state_t         state,
  input  logic           mem_ready,
  input  logic [OPW-1:0] opcode,
  output ctrl_word_t     ctrl
);

  always_comb begin
    // NOTE: every field defaults to 0 before the case so no path leaves a
    // field unassigned, which would otherwise infer a latch.
    ctrl = '0;
    case (state)
      S_IF: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PCSRC_ALU;
        // Stalled fetch must not advance PC or overwrite IR.
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_ID: begin
        // Speculative branch target into ALUOut.
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.pc_write_cond = 1'b1;
      end
      S_IMMEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = (opcode == OP_ORI) ? ALU_OR : ALU_ADD;
      end
      S_IMMWB: begin
        ctrl.reg_write = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_source = PCSRC_JUMP;
        ctrl.pc_write  = 1'b1;
      end
      default: ;  // illegal encodings: all controls inactive
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle processor.
// Sequences each instruction through fetch/decode/execute/memory/writeback
// and drives all datapath selects and write enables via the interface.
//   clk  in  system clock, rising edge
//   rst  in  asynchronous active-high reset
//   bus  master modport: opcode/mem_ready in; controls, bad_op, state out
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  multicycle_ctrl_if.master   bus
);

  state_t     state_q;
  state_t     state_d;
  logic       bad_op_q;
  ctrl_word_t ctrl;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of process ordering.
    if (rst) state_q <= S_IF;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = S_IF;
    case (state_q)
      S_IF:     state_d = bus.mem_ready ? S_ID : S_IF;
      S_ID: begin
        case (bus.opcode)
          OP_LW, OP_SW:    state_d = S_MEMADR;
          OP_RTYPE:        state_d = S_EXEC;
          OP_BEQ:          state_d = S_BRANCH;
          OP_J:            state_d = S_JUMP;
          OP_ADDI, OP_ORI: state_d = S_IMMEX;
          default:         state_d = S_IF;
        endcase
      end
      S_MEMADR: state_d = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = bus.mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = bus.mem_ready ? S_IF : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_IMMEX:  state_d = S_IMMWB;
      default:  state_d = S_IF;  // writeback/branch/jump done, or illegal
    endcase
  end

  // One-cycle flag for an unsupported opcode seen during decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) bad_op_q <= 1'b0;
    else     bad_op_q <= (state_q == S_ID) && !op_supported(bus.opcode);
  end

  // Output decode.
  multicycle_ctrl_out_decode u_out_decode (
    .state     (state_q),
    .mem_ready (bus.mem_ready),
    .opcode    (bus.opcode),
    .ctrl      (ctrl)
  );

  assign bus.pc_write      = ctrl.pc_write;
  assign bus.pc_write_cond = ctrl.pc_write_cond;
  assign bus.iord          = ctrl.iord;
  assign bus.mem_read      = ctrl.mem_read;
  assign bus.mem_write     = ctrl.mem_write;
  assign bus.ir_write      = ctrl.ir_write;
  assign bus.reg_dst       = ctrl.reg_dst;
  assign bus.mem_to_reg    = ctrl.mem_to_reg;
  assign bus.reg_write     = ctrl.reg_write;
  assign bus.alu_src_a     = ctrl.alu_src_a;
  assign bus.alu_src_b     = ctrl.alu_src_b;
  assign bus.alu_op        = ctrl.alu_op;
  assign bus.pc_source     = ctrl.pc_source;
  assign bus.bad_op        = bad_op_q;
  assign bus.state         = state_q;

endmodule
